// File: rtl/bcd_pkg.sv
// Shared BCD constants, FSM state type and digit-count helper for the
// binary-to-BCD converter and the downstream BCD adder.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned ADJ_THRESH  = 5;
  localparam int unsigned ADJ_ADD     = 3;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_e;

  // Decimal digits needed to print 2^w-1, i.e. ceil(w*log10(2)) (at least 1).
  function automatic int unsigned min_digits(input int unsigned w);
    logic [63:0] v;
    int unsigned n;
    v = (64'd1 << w) - 64'd1;
    n = 0;
    for (int unsigned i = 0; i < 20; i++) begin
      if (v != 64'd0) begin
        n++;
        v = v / 64'd10;
      end
    end
    return (n == 0) ? 1 : n;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_in,
  output logic [BCD_DIGIT_W-1:0] d_out
);

  always_comb begin
    d_out = d_in;
    if (d_in >= BCD_DIGIT_W'(ADJ_THRESH)) begin
      d_out = d_in + BCD_DIGIT_W'(ADJ_ADD);
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// clock, with a start/busy/done handshake.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out
);

  localparam int unsigned SCR_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  if (BIN_W < 1 || BIN_W > 32) begin : g_bad_bin_w
    $error("bin_to_bcd_seq: BIN_W must be in 1..32");
  end
  if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
  end

  state_e             state_q,   state_d;
  logic [BIN_W-1:0]   binreg_q,  binreg_d;
  logic [SCR_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [SCR_W-1:0]   bcd_q,     bcd_d;
  logic               done_q,    done_d;

  logic [SCR_W-1:0]       adj;
  logic [SCR_W+BIN_W-1:0] shifted;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_in  (scratch_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .d_out (adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // The scratch MSB shifted out here is always 0 when DIGITS is large enough.
  always_comb begin
    shifted = {adj, binreg_q} << 1;
  end

  always_comb begin
    state_d   = state_q;
    binreg_d  = binreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          binreg_d  = bin_in;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = shifted[SCR_W+BIN_W-1:BIN_W];
        binreg_d  = shifted[BIN_W-1:0];
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        bcd_d   = scratch_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      binreg_q  <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      binreg_q  <= binreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (BIN_W=8, DIGITS=3).
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int unsigned v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Pulse start for one cycle, wait (bounded) for done, check latency/busy/result.
  task automatic convert(input string tag, input logic [7:0] v, input logic [11:0] exp);
    int unsigned n;
    int unsigned busy_low;
    start  = 1'b1;
    bin_in = v;
    tick();
    start  = 1'b0;
    n = 0;
    busy_low = 0;
    while (!done && n < 20) begin
      if (!busy) busy_low++;
      tick();
      n++;
    end
    check({tag, " latency"}, n, 9);
    check({tag, " busy gaps"}, busy_low, 0);
    check({tag, " busy at done"}, busy, 1'b0);
    check({tag, " bcd_out"}, bcd_out, exp);
    tick();
    check({tag, " done one cycle"}, done, 1'b0);
  endtask

  initial begin
    int unsigned n;
    int unsigned cnt;
    int unsigned bad;

    rst = 1'b1; start = 1'b0; bin_in = '0;
    tick();
    tick();
    rst = 1'b0;

    // 1. Idle after reset
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 12'h000) bad++;
      tick();
    end
    check("reset idle", bad, 0);

    // 2. Single conversions
    convert("c255", 8'd255, 12'h255);
    convert("c0",   8'd0,   12'h000);
    convert("c99",  8'd99,  12'h099);
    convert("c100", 8'd100, 12'h100);

    // 3. Start and input change while busy are ignored
    start = 1'b1; bin_in = 8'd37;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; bin_in = 8'd200;
    tick();
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        cnt++;
        check("ignored start bcd", bcd_out, 12'h037);
      end
      tick();
    end
    check("ignored start done count", cnt, 1);
    check("ignored start idle", busy, 1'b0);

    // 4. Back-to-back with start held high, then hold
    start = 1'b1; bin_in = 8'd128;
    tick();
    bin_in = 8'd9;
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
    check("b2b first latency", n, 9);
    check("b2b first bcd", bcd_out, 12'h128);
    tick();
    n = 1;
    while (!done && n < 20) begin tick(); n++; end
    check("b2b spacing", n, 10);
    check("b2b second bcd", bcd_out, 12'h009);
    start = 1'b0;
    tick();
    bad = 0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bcd_out !== 12'h009) bad++;
      if (done) cnt++;
      tick();
    end
    check("hold bcd", bad, 0);
    check("hold no done", cnt, 0);

    // 5. Reset mid-conversion
    start = 1'b1; bin_in = 8'd173;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort bcd", bcd_out, 12'h000);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) cnt++;
      tick();
    end
    check("abort no done", cnt, 0);
    convert("c173", 8'd173, 12'h173);

    // 6. All inputs against a decimal reference
    for (int unsigned v = 0; v < 256; v++) begin
      convert($sformatf("all%0d", v), 8'(v), ref_bcd(v));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
